// File: rtl/ts_pkg.sv
// Shared MPEG2-TS constants and types, used by the packetizer and by the sync-recovery receiver.
package ts_pkg;

    localparam logic [7:0]  SYNC_BYTE   = 8'h47;
    localparam logic [7:0]  NULL_BYTE   = 8'hFF;
    localparam logic [7:0]  PKT_LEN     = 8'd188;
    localparam logic [7:0]  HDR_LEN     = 8'd4;
    localparam logic [12:0] NULL_PID    = 13'h1FFF;
    localparam logic [1:0]  AFC_PAYLOAD = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } state_t;

    typedef enum logic {
        DATA = 1'b0,
        NULL = 1'b1
    } kind_t;

endpackage

// File: rtl/ts_header_gen.sv
// Combinational TS header byte mux: picks sync/header byte 0..3 for the current packet.
module ts_header_gen
    import ts_pkg::*;
(
    input  logic [1:0]  sel,
    input  kind_t       kind,
    input  logic        pusi,
    input  logic [12:0] pid,
    input  logic [3:0]  cc,
    output logic [7:0]  hdr_byte
);

    logic [12:0] pid_eff;
    logic        pusi_eff;
    logic [3:0]  cc_eff;

    // Null packets carry a fixed header regardless of the committed flags.
    always_comb begin
        pid_eff  = (kind == DATA) ? pid : NULL_PID;
        pusi_eff = (kind == DATA) ? pusi : 1'b0;
        cc_eff   = (kind == DATA) ? cc : 4'd0;
        case (sel)
            2'd1:    hdr_byte = {1'b0, pusi_eff, 1'b0, pid_eff[12:8]};
            2'd2:    hdr_byte = pid_eff[7:0];
            2'd3:    hdr_byte = {2'b00, AFC_PAYLOAD, cc_eff};
            default: hdr_byte = SYNC_BYTE;
        endcase
    end

endmodule

// File: rtl/ts_packetizer.sv
// Transmit-side TS framer: wraps a payload byte stream into 188-byte packets, null-filling when idle.
module ts_packetizer
    import ts_pkg::*;
#(
    parameter logic [12:0] PID       = 13'h0100,
    parameter bit          NULL_FILL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_pusi,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sync,
    output logic [3:0] cc
);

    state_t     state;
    kind_t      kind;
    logic [7:0] idx;
    logic [3:0] cc_q;
    logic       pusi_q;
    logic [7:0] hdr_byte;
    logic       xfer;

    ts_header_gen u_header_gen (
        .sel      (idx[1:0]),
        .kind     (kind),
        .pusi     (pusi_q),
        .pid      (PID),
        .cc       (cc_q),
        .hdr_byte (hdr_byte)
    );

    // Outputs are purely combinational so payload bytes pass straight through.
    always_comb begin
        out_data  = SYNC_BYTE;
        out_sync  = 1'b0;
        out_valid = 1'b0;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                out_sync  = 1'b1;
                out_valid = in_valid | NULL_FILL;
            end
            HDR: begin
                out_data  = hdr_byte;
                out_valid = 1'b1;
            end
            PAY: begin
                if (kind == DATA) begin
                    out_data  = in_data;
                    out_valid = in_valid;
                    in_ready  = out_ready;
                end else begin
                    out_data  = NULL_BYTE;
                    out_valid = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign xfer = out_valid & out_ready;
    assign cc   = cc_q;

    // Packet kind and PUSI are latched at the sync byte so later input changes cannot alter the header.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= 8'd0;
            cc_q   <= 4'd0;
            kind   <= DATA;
            pusi_q <= 1'b0;
        end else if (xfer) begin
            case (state)
                IDLE: begin
                    kind   <= in_valid ? DATA : NULL;
                    pusi_q <= in_valid & in_pusi;
                    idx    <= 8'd1;
                    state  <= HDR;
                end
                HDR: begin
                    idx <= idx + 8'd1;
                    if (idx == HDR_LEN - 8'd1) begin
                        state <= PAY;
                    end
                end
                PAY: begin
                    if (idx == PKT_LEN - 8'd1) begin
                        idx   <= 8'd0;
                        state <= IDLE;
                        if (kind == DATA) begin
                            cc_q <= cc_q + 4'd1;
                        end
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                default: begin
                    idx   <= 8'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ts_packetizer.sv
// Directed bench for ts_packetizer: null fill, data framing, cc wrap, stalls and reset truncation.
module tb_ts_packetizer;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_pusi;
    logic       out_ready;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_sync;
    logic [3:0] cc;
    logic       nf_in_ready;
    logic [7:0] nf_out_data;
    logic       nf_out_valid;
    logic       nf_out_sync;
    logic [3:0] nf_cc;

    int checks = 0;
    int errors = 0;

    ts_packetizer #(.PID(13'h0100), .NULL_FILL(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_pusi   (in_pusi),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sync  (out_sync),
        .cc        (cc)
    );

    // Second instance without null fill, sharing the same stimulus.
    ts_packetizer #(.PID(13'h0100), .NULL_FILL(1'b0)) dut_nf (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_pusi   (in_pusi),
        .in_ready  (nf_in_ready),
        .out_data  (nf_out_data),
        .out_valid (nf_out_valid),
        .out_ready (out_ready),
        .out_sync  (nf_out_sync),
        .cc        (nf_cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic valid, input logic [7:0] data,
                                 input logic pusi, input logic ready);
        in_valid  = valid;
        in_data   = data;
        in_pusi   = pusi;
        out_ready = ready;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full packet; stalls adds a 5-cycle in_valid gap at idx 100 and out_ready drops at idx 2 and 50.
    task automatic runPacket(input bit data_pkt, input bit pusi, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3,
                             input logic [7:0] base, input bit stalls);
        logic [7:0] pay;
        logic [7:0] exp_byte;
        for (int i = 0; i < 188; i++) begin
            pay = 8'(i - 4) + base;
            case (i)
                0:       exp_byte = 8'h47;
                1:       exp_byte = e1;
                2:       exp_byte = e2;
                3:       exp_byte = e3;
                default: exp_byte = data_pkt ? pay : 8'hFF;
            endcase
            if (stalls && data_pkt && i == 100) begin
                for (int g = 0; g < 5; g++) begin
                    applyStimulus(1'b0, 8'hFF, ~pusi, 1'b1);
                    @(negedge clk);
                    checkOutput($sformatf("gap%0d_valid", g), {7'd0, out_valid}, 8'd0);
                    checkOutput($sformatf("gap%0d_ready", g), {7'd0, in_ready}, 8'd1);
                    tick();
                end
            end
            if (stalls && (i == 2 || i == 50)) begin
                for (int g = 0; g < 3; g++) begin
                    applyStimulus(data_pkt, (i >= 4) ? pay : 8'h00, ~pusi, 1'b0);
                    @(negedge clk);
                    checkOutput($sformatf("hold%0d_%0d_data", i, g), out_data, exp_byte);
                    checkOutput($sformatf("hold%0d_%0d_ready", i, g), {7'd0, in_ready}, 8'd0);
                    checkOutput($sformatf("hold%0d_%0d_valid", i, g), {7'd0, out_valid}, 8'd1);
                    tick();
                end
            end
            applyStimulus(data_pkt, (i >= 4) ? pay : 8'h00, (i == 0) ? pusi : ~pusi, 1'b1);
            @(negedge clk);
            checkOutput($sformatf("byte%0d_data", i), out_data, exp_byte);
            checkOutput($sformatf("byte%0d_valid", i), {7'd0, out_valid}, 8'd1);
            checkOutput($sformatf("byte%0d_sync", i), {7'd0, out_sync}, (i == 0) ? 8'd1 : 8'd0);
            checkOutput($sformatf("byte%0d_inready", i), {7'd0, in_ready},
                        (data_pkt && i >= 4) ? 8'd1 : 8'd0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_data", out_data, 8'h47);
        checkOutput("rst_sync", {7'd0, out_sync}, 8'd1);
        checkOutput("rst_cc", {4'd0, cc}, 8'd0);
        checkOutput("rst_inready", {7'd0, in_ready}, 8'd0);
        checkOutput("rst_nf_valid", {7'd0, nf_out_valid}, 8'd0);
        tick();
        rst = 1'b0;

        $display("[TB] null fill packets");
        runPacket(1'b0, 1'b0, 8'h1F, 8'hFF, 8'h10, 8'h00, 1'b0);
        runPacket(1'b0, 1'b1, 8'h1F, 8'hFF, 8'h10, 8'h00, 1'b0);
        checkOutput("null_cc", {4'd0, cc}, 8'd0);

        $display("[TB] data packets");
        runPacket(1'b1, 1'b1, 8'h41, 8'h00, 8'h10, 8'h00, 1'b0);
        checkOutput("cc_after_first", {4'd0, cc}, 8'd1);
        runPacket(1'b1, 1'b0, 8'h01, 8'h00, 8'h11, 8'h40, 1'b1);
        checkOutput("cc_after_stall", {4'd0, cc}, 8'd2);

        $display("[TB] continuity counter wrap");
        for (int k = 2; k < 16; k++) begin
            runPacket(1'b1, 1'b0, 8'h01, 8'h00, 8'h10 | 8'(k), 8'(k), 1'b0);
            if (k == 7) begin
                runPacket(1'b0, 1'b1, 8'h1F, 8'hFF, 8'h10, 8'h00, 1'b0);
                checkOutput("cc_after_null", {4'd0, cc}, 8'd8);
            end
        end
        checkOutput("cc_before_wrap", {4'd0, cc}, 8'd0);
        runPacket(1'b1, 1'b1, 8'h41, 8'h00, 8'h10, 8'h20, 1'b0);
        checkOutput("cc_after_wrap", {4'd0, cc}, 8'd1);

        $display("[TB] reset mid packet");
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b1, 1'b1);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("post_rst_data", out_data, 8'h47);
        checkOutput("post_rst_sync", {7'd0, out_sync}, 8'd1);
        checkOutput("post_rst_cc", {4'd0, cc}, 8'd0);
        checkOutput("post_rst_valid", {7'd0, out_valid}, 8'd1);
        checkOutput("post_rst_nf_valid", {7'd0, nf_out_valid}, 8'd0);
        tick();
        @(negedge clk);
        checkOutput("post_rst_hdr1", out_data, 8'h1F);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            checkOutput($sformatf("nf_idle%0d_valid", i), {7'd0, nf_out_valid}, 8'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
